// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================
// mixer_pkg : FSM encoding, mute code and clog2 for mixer_nch
// Rev 1.0
// ============================================================
package mixer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Wide all-ones word; users slice the low LEVEL_W bits.
   localparam logic [15:0] MUTE_CODE = 16'hFFFF;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_atten.sv
`default_nettype none
// ============================================================
// mixer_atten : per-channel attenuation (mute or logical shift)
// Rev 1.0
// ============================================================
module mixer_atten
   import mixer_pkg::*;
#(
   parameter int SAMPLE_W = 8,
   parameter int LEVEL_W  = 3
) (
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [LEVEL_W-1:0]  level,
   output logic [SAMPLE_W-1:0] atten
);

   always_comb begin
      if (level == MUTE_CODE[LEVEL_W-1:0]) begin
         atten = '0;
      end else begin
         atten = sample >> level;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mixer_nch.sv
`default_nettype none
// ============================================================
// mixer_nch : sequential N-channel attenuating mixer with saturation
// Rev 1.0
// ============================================================
module mixer_nch
   import mixer_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int SAMPLE_W = 8,
   parameter int LEVEL_W  = 3,
   parameter int OUT_W    = 12
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [SAMPLE_W-1:0]         i_sample,
   input  logic [clog2(NUM_CH)-1:0]    i_load_ch,
   input  logic                        i_load,
   input  logic [NUM_CH*LEVEL_W-1:0]   i_level,
   input  logic                        i_execute,
   output logic [OUT_W-1:0]            o_output,
   output logic                        o_busy,
   output logic                        o_valid,
   output logic                        o_clip
);

   localparam int IDX_W = clog2(NUM_CH);
   localparam int ACC_W = SAMPLE_W + IDX_W;
   localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam logic [CMP_W-1:0] OUT_MAX = (CMP_W'(1) << OUT_W) - CMP_W'(1);

   state_t              state;
   logic [SAMPLE_W-1:0] samples [NUM_CH];
   logic [LEVEL_W-1:0]  levels  [NUM_CH];
   logic [ACC_W-1:0]    acc;
   logic [IDX_W-1:0]    idx;
   logic [SAMPLE_W-1:0] cur_atten;
   logic [CMP_W-1:0]    acc_ext;
   logic                load_ok;

   assign acc_ext = CMP_W'(acc);

   // Out-of-range channel codes only exist when NUM_CH is not a power of two.
   generate
      if (NUM_CH == (1 << IDX_W)) begin : g_full_range
         assign load_ok = i_load;
      end else begin : g_range_check
         assign load_ok = i_load && (i_load_ch < IDX_W'(NUM_CH));
      end
   endgenerate

   mixer_atten #(
      .SAMPLE_W (SAMPLE_W),
      .LEVEL_W  (LEVEL_W)
   ) u_atten (
      .sample (samples[idx]),
      .level  (levels[idx]),
      .atten  (cur_atten)
   );

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state    <= ST_IDLE;
         acc      <= '0;
         idx      <= '0;
         o_output <= '0;
         o_busy   <= 1'b0;
         o_valid  <= 1'b0;
         o_clip   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            samples[k] <= '0;
            levels[k]  <= '0;
         end
      end else begin
         o_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_ok) begin
                  samples[i_load_ch] <= i_sample;
               end
               if (i_execute) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     levels[k] <= i_level[k*LEVEL_W +: LEVEL_W];
                  end
                  acc    <= '0;
                  idx    <= '0;
                  o_busy <= 1'b1;
                  state  <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               acc <= acc + ACC_W'(cur_atten);
               if (idx == IDX_W'(NUM_CH - 1)) begin
                  state <= ST_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               o_valid <= 1'b1;
               o_busy  <= 1'b0;
               state   <= ST_IDLE;
               if (acc_ext > OUT_MAX) begin
                  o_output <= '1;
                  o_clip   <= 1'b1;
               end else begin
                  o_output <= OUT_W'(acc);
                  o_clip   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mixer_nch.sv
`default_nettype none
// ============================================================
// tb_mixer_nch : table-driven, scoreboarded bench for mixer_nch
// Rev 1.0
// ============================================================
module tb_mixer_nch;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  sample;
   logic [1:0]  load_ch;
   logic        load;
   logic        execute;
   logic [11:0] level;

   logic [11:0] out_a;
   logic        busy_a, valid_a, clip_a;
   logic [8:0]  out_b;
   logic        busy_b, valid_b, clip_b;

   always #5 clk = ~clk;

   mixer_nch #(.NUM_CH(4), .SAMPLE_W(8), .LEVEL_W(3), .OUT_W(12)) dut_a (
      .i_clock(clk), .i_reset(rst_n), .i_sample(sample), .i_load_ch(load_ch),
      .i_load(load), .i_level(level), .i_execute(execute),
      .o_output(out_a), .o_busy(busy_a), .o_valid(valid_a), .o_clip(clip_a)
   );

   mixer_nch #(.NUM_CH(4), .SAMPLE_W(8), .LEVEL_W(3), .OUT_W(9)) dut_b (
      .i_clock(clk), .i_reset(rst_n), .i_sample(sample), .i_load_ch(load_ch),
      .i_load(load), .i_level(level), .i_execute(execute),
      .o_output(out_b), .o_busy(busy_b), .o_valid(valid_b), .o_clip(clip_b)
   );

   typedef struct {
      int out;
      int clip;
      int due;
   } exp_t;

   typedef struct {
      logic [31:0] s;
      logic [11:0] lvl;
      int          out_a;
      int          clip_a;
      int          out_b;
      int          clip_b;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];
   vec_t vt[12];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d,
                               input logic [11:0] l, input int oa, input int ca,
                               input int ob, input int cb);
      vec_t v;
      v.s = {d, c, b, a};
      v.lvl = l;
      v.out_a = oa;
      v.clip_a = ca;
      v.out_b = ob;
      v.clip_b = cb;
      return v;
   endfunction

   // Scoreboard: results are popped as each DUT raises its valid strobe.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (valid_a) begin
         if (qa.size() == 0) chk("unexpected_valid_a", 1, 0);
         else begin
            e = qa.pop_front();
            chk("out_a", int'(out_a), e.out);
            chk("clip_a", int'(clip_a), e.clip);
            chk("latency_a", cyc, e.due);
         end
      end
      if (valid_b) begin
         if (qb.size() == 0) chk("unexpected_valid_b", 1, 0);
         else begin
            e = qb.pop_front();
            chk("out_b", int'(out_b), e.out);
            chk("clip_b", int'(clip_b), e.clip);
            chk("latency_b", cyc, e.due);
         end
      end
   end

   task automatic wait_drain();
      int k;
      k = 0;
      while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", qa.size() + qb.size(), 0);
      qa.delete();
      qb.delete();
   endtask

   task automatic load_one(input int ch, input int val);
      @(negedge clk);
      load = 1'b1; load_ch = 2'(ch); sample = 8'(val);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic push_exp(input int oa, input int ca, input int ob, input int cb);
      qa.push_back('{oa, ca, cyc + N + 2});
      qb.push_back('{ob, cb, cyc + N + 2});
   endtask

   // Channel 3 is loaded on the execute edge itself; levels are scrambled right after.
   task automatic run_vec(input vec_t v);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         load = 1'b1; load_ch = 2'(k); sample = v.s[k*8 +: 8];
      end
      @(negedge clk);
      load_ch = 2'd3; sample = v.s[31:24]; level = v.lvl; execute = 1'b1;
      push_exp(v.out_a, v.clip_a, v.out_b, v.clip_b);
      @(negedge clk);
      load = 1'b0; execute = 1'b0; level = ~v.lvl;
      chk("busy_a", int'(busy_a), 1);
      wait_drain();
      @(negedge clk);
      chk("hold_out_a", int'(out_a), v.out_a);
      chk("hold_clip_b", int'(clip_b), v.clip_b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = mk(60, 80, 0, 0,       12'h000,  140, 0, 140, 0);
      vt[1]  = mk(60, 80, 0, 0,       12'h007,   80, 0,  80, 0);
      vt[2]  = mk(60, 80, 0, 0,       12'h038,   60, 0,  60, 0);
      vt[3]  = mk(60, 80, 0, 0,       12'h009,   70, 0,  70, 0);
      vt[4]  = mk(255, 255, 255, 255, 12'h000, 1020, 0, 511, 1);
      vt[5]  = mk(10, 0, 0, 0,        12'h000,   10, 0,  10, 0);
      vt[6]  = mk(255, 255, 255, 255, 12'hED1,  221, 0, 221, 0);
      vt[7]  = mk(200, 100, 50, 255,  12'h006,  408, 0, 408, 0);
      vt[8]  = mk(255, 255, 255, 0,   12'h000,  765, 0, 511, 1);
      vt[9]  = mk(129, 128, 1, 2,     12'h828,  134, 0, 134, 0);
      vt[10] = mk(255, 255, 1, 0,     12'h000,  511, 0, 511, 0);
      vt[11] = mk(255, 255, 2, 0,     12'h000,  512, 0, 511, 1);

      rst_n = 1'b0; sample = '0; load_ch = '0; load = 1'b0; execute = 1'b0; level = '0;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sample = 8'($urandom); load_ch = 2'($urandom); load = 1'($urandom);
         execute = 1'($urandom); level = 12'($urandom);
         @(posedge clk);
         #1;
         chk("reset_outputs", int'({out_a, busy_a, valid_a, clip_a, out_b, busy_b, valid_b, clip_b}), 0);
      end
      @(negedge clk);
      load = 1'b0; execute = 1'b0; level = '0;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(vt[i]);

      // Execute, load and level changes while busy must not disturb the mix.
      load_one(0, 60); load_one(1, 80); load_one(2, 0); load_one(3, 0);
      @(negedge clk);
      level = 12'h000; execute = 1'b1;
      push_exp(140, 0, 140, 0);
      @(negedge clk);
      chk("busy_accum_b", int'(busy_b), 1);
      execute = 1'b1; load = 1'b1; load_ch = 2'd0; sample = 8'd200; level = 12'hFFF;
      @(negedge clk);
      execute = 1'b0; load = 1'b0;
      wait_drain();
      repeat (8) @(negedge clk);
      level = 12'h000; execute = 1'b1;
      push_exp(140, 0, 140, 0);
      @(negedge clk);
      execute = 1'b0;
      wait_drain();

      // Reset in the second ACCUM cycle aborts the mix and clears the samples.
      load_one(0, 50);
      @(negedge clk);
      level = 12'h000; execute = 1'b1;
      @(negedge clk);
      execute = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_clear_a", int'({out_a, busy_a, valid_a, clip_a}), 0);
      chk("abort_clear_b", int'({out_b, busy_b, valid_b, clip_b}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      execute = 1'b1;
      push_exp(0, 0, 0, 0);
      @(negedge clk);
      execute = 1'b0;
      wait_drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mixer_nch.md
MIXER_NCH -- requirements
Module: mixer_nch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_CH, 4, channel count (2..16)
  SAMPLE_W, 8, unsigned sample width
  LEVEL_W, 3, per-channel attenuation code width
  OUT_W, 12, output width (may be smaller than the full-sum width)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  i_clock, in, 1, sole clock, rising edge
  i_reset, in, 1, asynchronous active-low reset
  i_sample, in, SAMPLE_W, sample data to load
  i_load_ch, in, clog2(NUM_CH), target channel for load
  i_load, in, 1, load strobe
  i_level, in, NUM_CH*LEVEL_W, packed levels; channel k occupies bits [k*LEVEL_W +: LEVEL_W]
  i_execute, in, 1, start-mix strobe
  o_output, out, OUT_W, last mix result
  o_busy, out, 1, mix in progress
  o_valid, out, 1, one-cycle result strobe
  o_clip, out, 1, last result saturated
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL hold one SAMPLE_W register per channel; in IDLE, i_load=1 SHALL write i_sample to channel i_load_ch at the clock edge.
REQ-005 A load with i_load_ch>=NUM_CH SHALL be ignored, and a load while o_busy=1 SHALL be dropped.
REQ-006 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-007 In IDLE, i_execute=1 SHALL snapshot i_level, clear the accumulator and channel index, and enter ACCUM.
REQ-008 ACCUM SHALL add the attenuated value of channel index k per cycle, k=0..NUM_CH-1, then enter DONE.
REQ-009 DONE SHALL register the result into o_output, pulse o_valid for one cycle, and return to IDLE.
REQ-010 o_busy SHALL be 1 in ACCUM and DONE; i_execute while busy SHALL be ignored.
REQ-011 Latency: for i_execute sampled at edge t, o_valid SHALL be high in the cycle after edge t+NUM_CH+1.
REQ-012 Attenuation: level code all-ones SHALL mute the channel (contributes 0); any other code L SHALL contribute sample >> L (logical shift).
REQ-013 The accumulator SHALL be SAMPLE_W+clog2(NUM_CH) bits wide and SHALL never wrap.
REQ-014 If the sum exceeds 2^OUT_W-1, o_output SHALL be 2^OUT_W-1 and o_clip SHALL be 1; otherwise o_output SHALL be the zero-extended sum and o_clip SHALL be 0.
REQ-015 o_output and o_clip SHALL hold their values until the next DONE.
REQ-016 Simultaneous i_load and i_execute in IDLE SHALL both take effect, and the new sample SHALL be included in the mix.
REQ-017 i_level changes after the execute edge SHALL NOT affect the mix in progress.

Reset
REQ-018 i_reset=0 SHALL immediately force IDLE and clear o_output, o_busy, o_valid, o_clip, all sample registers, the accumulator, the index and the level snapshot.
REQ-019 Reset asserted mid-ACCUM SHALL abort the mix with no o_valid pulse.

Structure
REQ-020 Package mixer_pkg SHALL hold the FSM state encoding, the mute-code constant (all-ones of LEVEL_W), and a clog2 function.
REQ-021 One combinational sub-module, mixer_atten (sample and level in, attenuated value out), SHALL implement REQ-012; mixer_nch SHALL contain a single instance of it, muxed by the channel index.

Verification
REQ-022 Reset: hold i_reset=0, apply random inputs -> all outputs remain 0 and o_busy=0.
REQ-023 Basic mix (defaults): load ch0=60, ch1=80, ch2=0, ch3=0, all levels 0, execute -> o_valid 5 cycles later, o_output=140, o_clip=0.
REQ-024 Levels: ch0 code 7 -> 80; then ch0 code 0, ch1 code 7 -> 60; then ch0 and ch1 both code 1 -> 70.
REQ-025 Saturation: OUT_W=9 instance, all four channels 255 at level 0 -> o_output=511, o_clip=1; a following mix of 10 -> 10, o_clip=0.
REQ-026 Busy rules: during ACCUM, pulse i_execute, load ch0=200 and change i_level -> single o_valid, result unchanged, ch0 keeps its old value.
REQ-027 Abort: assert reset at the second ACCUM cycle, then release and execute with zero samples -> no o_valid before the re-execute, o_output=0.
